// File: rtl/sdrd_byte_capture_if.sv
// Bus-side signal bundle for sdrd_byte_capture.
//   master : drives the decoded bus qualifiers, serial read bit and consumer ack
//   slave  : the capture block; returns the assembled byte and status
//   sser, ba13, ba12, br_w : bus qualifiers forming the read window
//   sdrd                   : resolved serial read-data bit
//   data_ack               : consumer accepts data_out
//   data_out[7:0]          : last completed byte
//   data_valid             : data_out holds an unaccepted byte
//   overrun                : sticky, a completed byte was dropped
//   frame_err              : one-clock pulse, partial byte discarded by timeout
//   bit_cnt[2:0]           : bits held in the current partial byte
interface sdrd_byte_capture_if;
  logic       sser;
  logic       ba13;
  logic       ba12;
  logic       br_w;
  logic       sdrd;
  logic       data_ack;
  logic [7:0] data_out;
  logic       data_valid;
  logic       overrun;
  logic       frame_err;
  logic [2:0] bit_cnt;

  modport master (
    output sser, ba13, ba12, br_w, sdrd, data_ack,
    input  data_out, data_valid, overrun, frame_err, bit_cnt
  );

  modport slave (
    input  sser, ba13, ba12, br_w, sdrd, data_ack,
    output data_out, data_valid, overrun, frame_err, bit_cnt
  );
endinterface

// File: rtl/sdrd_byte_capture.sv
// Serial read-data byte capture.
// One bit is taken per bus read window (~sser & ~ba13 & ba12 & br_w) on the
// window's trailing edge; eight bits form a byte presented on data_out with a
// valid/ack handshake. A partial byte left idle for TIMEOUT clocks is
// discarded with a frame_err pulse.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sdrd_byte_capture_if.slave (qualifiers, sdrd, ack, byte, status)
// Parameters:
//   TIMEOUT   : idle clocks before a partial byte is discarded (2..65535)
//   MSB_FIRST : 1 = first bit lands in data_out[7], 0 = in data_out[0]
module sdrd_byte_capture #(
  parameter int unsigned TIMEOUT   = 1024,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sdrd_byte_capture_if.slave    bus
);

  localparam logic [15:0] TMO    = 16'(TIMEOUT);
  localparam logic [15:0] TMO_M1 = 16'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t      state, state_nxt;

  logic        win;
  logic        win_q;
  logic        sdrd_q;
  logic        cap;
  logic        tmo_hit;
  logic [15:0] idle_cnt;

  logic [7:0]  shreg;
  logic [7:0]  shreg_shifted;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  data_out_r;
  logic        data_valid_r;
  logic        overrun_r;
  logic        frame_err_r;

  logic        do_shift;
  logic        do_complete;
  logic        do_timeout;
  logic        accept;
  logic        load;
  logic        drop;

  assign win     = ~bus.sser & ~bus.ba13 & bus.ba12 & bus.br_w;
  assign cap     = win_q & ~win;
  // A capture clock always follows a window clock, so idle_cnt is 0 there and
  // tmo_hit cannot coincide with cap for TIMEOUT >= 2.
  assign tmo_hit = ~win & (idle_cnt == TMO_M1);

  always_comb begin
    if (MSB_FIRST) shreg_shifted = {shreg[6:0], sdrd_q};
    else           shreg_shifted = {sdrd_q, shreg[7:1]};
  end

  // Window tracking and last in-window sdrd sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= 1'b0;
      sdrd_q <= 1'b0;
    end else begin
      win_q <= win;
      if (win) sdrd_q <= bus.sdrd;
    end
  end

  // Idle counter: cleared by any window clock, saturates at TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             idle_cnt <= '0;
    else if (win)           idle_cnt <= '0;
    else if (idle_cnt != TMO) idle_cnt <= idle_cnt + 16'd1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cap) state_nxt = SHIFT;
      SHIFT: begin
        if (cap && (bit_cnt_r == 3'd7)) state_nxt = IDLE;
        else if (tmo_hit)               state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: datapath strobes.
  always_comb begin
    do_shift    = 1'b0;
    do_complete = 1'b0;
    do_timeout  = 1'b0;
    case (state)
      IDLE: do_shift = cap;
      SHIFT: begin
        if (cap) begin
          do_shift    = 1'b1;
          do_complete = (bit_cnt_r == 3'd7);
        end else if (tmo_hit) begin
          do_timeout = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign accept = data_valid_r & bus.data_ack;
  assign load   = do_complete & (~data_valid_r | bus.data_ack);
  assign drop   = do_complete & data_valid_r & ~bus.data_ack;

  // Shift register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      bit_cnt_r <= '0;
    end else if (do_complete || do_timeout) begin
      shreg     <= '0;
      bit_cnt_r <= '0;
    end else if (do_shift) begin
      shreg     <= shreg_shifted;
      bit_cnt_r <= bit_cnt_r + 3'd1;
    end
  end

  // Output byte, handshake and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      frame_err_r <= do_timeout;
      if (load) data_out_r <= shreg_shifted;

      if (load)        data_valid_r <= 1'b1;
      else if (accept) data_valid_r <= 1'b0;

      if (drop)        overrun_r <= 1'b1;
      else if (accept) overrun_r <= 1'b0;
    end
  end

  assign bus.data_out   = data_out_r;
  assign bus.data_valid = data_valid_r;
  assign bus.overrun    = overrun_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.bit_cnt    = bit_cnt_r;

endmodule

// File: tb/tb_sdrd_byte_capture.sv
// Bench for sdrd_byte_capture: two instances (MSB_FIRST=1 and 0, TIMEOUT=16)
// share the same stimulus; a bit-list model predicts every output each cycle.
module tb_sdrd_byte_capture;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic sser, ba13, ba12, br_w, sdrd, ack;

  always #5 clk = ~clk;

  sdrd_byte_capture_if if0 ();
  sdrd_byte_capture_if if1 ();

  assign if0.sser = sser;  assign if1.sser = sser;
  assign if0.ba13 = ba13;  assign if1.ba13 = ba13;
  assign if0.ba12 = ba12;  assign if1.ba12 = ba12;
  assign if0.br_w = br_w;  assign if1.br_w = br_w;
  assign if0.sdrd = sdrd;  assign if1.sdrd = sdrd;
  assign if0.data_ack = ack;
  assign if1.data_ack = ack;

  sdrd_byte_capture #(.TIMEOUT(TO), .MSB_FIRST(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  sdrd_byte_capture #(.TIMEOUT(TO), .MSB_FIRST(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- model: list of captured bits per instance ----------------
  bit         msb [2] = '{1'b1, 1'b0};
  logic       m_winq [2], m_sdrdq [2];
  int         m_idle [2], m_nbits [2];
  logic       m_bits [2][8];
  logic [7:0] m_dout [2];
  logic       m_valid [2], m_ov [2], m_ferr [2];
  logic       m_w, m_cap, m_tmo, m_cmp, m_acc, m_wasv;
  int         m_byte;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_winq[k] = 0; m_sdrdq[k] = 0; m_idle[k] = 0; m_nbits[k] = 0;
        m_dout[k] = 8'h00; m_valid[k] = 0; m_ov[k] = 0; m_ferr[k] = 0;
      end
    end else begin
      m_w = !sser && !ba13 && ba12 && br_w;
      for (int k = 0; k < 2; k++) begin
        m_cap  = m_winq[k] && !m_w;
        m_tmo  = !m_w && (m_nbits[k] > 0) && (m_idle[k] == TO - 1);
        m_ferr[k] = m_tmo;
        if (m_tmo) m_nbits[k] = 0;
        m_cmp = 0;
        if (m_cap) begin
          m_bits[k][m_nbits[k]] = m_sdrdq[k];
          m_nbits[k]++;
          if (m_nbits[k] == 8) begin
            m_cmp = 1;
            m_nbits[k] = 0;
            m_byte = 0;
            for (int i = 0; i < 8; i++)
              if (m_bits[k][i]) m_byte += msb[k] ? (1 << (7 - i)) : (1 << i);
          end
        end
        m_wasv = m_valid[k];
        m_acc  = m_wasv && ack;
        if (m_cmp && (!m_wasv || ack)) begin
          m_dout[k]  = m_byte[7:0];
          m_valid[k] = 1;
        end else if (m_acc) m_valid[k] = 0;
        if (m_cmp && m_wasv && !ack) m_ov[k] = 1;
        else if (m_acc)              m_ov[k] = 0;
        m_idle[k] = m_w ? 0 : ((m_idle[k] < TO) ? m_idle[k] + 1 : TO);
        m_winq[k] = m_w;
        if (m_w) m_sdrdq[k] = sdrd;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("d0_data_out",   {24'd0, if0.data_out}, {24'd0, m_dout[0]});
    chk("d0_data_valid", {31'd0, if0.data_valid}, {31'd0, m_valid[0]});
    chk("d0_overrun",    {31'd0, if0.overrun},    {31'd0, m_ov[0]});
    chk("d0_frame_err",  {31'd0, if0.frame_err},  {31'd0, m_ferr[0]});
    chk("d0_bit_cnt",    {29'd0, if0.bit_cnt},    32'(m_nbits[0]));
    chk("d1_data_out",   {24'd0, if1.data_out}, {24'd0, m_dout[1]});
    chk("d1_data_valid", {31'd0, if1.data_valid}, {31'd0, m_valid[1]});
    chk("d1_overrun",    {31'd0, if1.overrun},    {31'd0, m_ov[1]});
    chk("d1_frame_err",  {31'd0, if1.frame_err},  {31'd0, m_ferr[1]});
    chk("d1_bit_cnt",    {29'd0, if1.bit_cnt},    32'(m_nbits[1]));
  end

  // ---------------- stimulus helpers ----------------
  task automatic clk1();
    @(negedge clk);
  endtask

  task automatic rest();
    sser = 1'b1; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1;
  endtask

  // Open a window for len clocks (sdrd = ~b until the last window clock),
  // then close it by a randomly chosen qualifier; ack_close drives data_ack
  // on the trailing-edge (capture) clock.
  task automatic win_bit(input logic b, input int len, input logic ack_close);
    sser = 1'b0; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1;
    for (int i = 0; i < len; i++) begin
      sdrd = (i == len - 1) ? b : ~b;
      clk1();
    end
    case ($urandom_range(0, 3))
      0: sser = 1'b1;
      1: ba13 = 1'b1;
      2: ba12 = 1'b0;
      default: br_w = 1'b0;
    endcase
    sdrd = 1'($urandom);
    ack = ack_close;
    clk1();
    ack = 1'b0;
    rest();
  endtask

  task automatic send_byte(input logic [7:0] v, input int len, input logic ack_last);
    for (int i = 7; i >= 0; i--)
      win_bit(v[i], len, (i == 0) ? ack_last : 1'b0);
  endtask

  // Near-miss bus cycles: three of four qualifiers active, sdrd toggling.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sser = 1'b0; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1;
      case ($urandom_range(0, 3))
        0: sser = 1'b1;
        1: ba13 = 1'b1;
        2: ba12 = 1'b0;
        default: br_w = 1'b0;
      endcase
      sdrd = 1'($urandom);
      clk1();
    end
    rest();
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    clk1();
    ack = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; ack = 1'b0; sdrd = 1'b0;
    rest();
    repeat (3) clk1();
    chk("reset_data_out", {24'd0, if0.data_out}, 32'h00);
    chk("reset_valid",    {31'd0, if0.data_valid}, 32'd0);
    chk("reset_bit_cnt",  {29'd0, if0.bit_cnt}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // 3-clock windows, 1,0,1,0,0,1,0,1
    send_byte(8'hA5, 3, 1'b0);
    chk("a5_msb_out",   {24'd0, if0.data_out}, 32'hA5);
    chk("a5_msb_valid", {31'd0, if0.data_valid}, 32'd1);
    chk("a5_bit_cnt",   {29'd0, if0.bit_cnt}, 32'd0);
    ack_pulse();
    chk("ack_clears_valid", {31'd0, if0.data_valid}, 32'd0);
    chk("ack_keeps_out",    {24'd0, if0.data_out}, 32'hA5);
    ack_pulse();            // ack with nothing valid: ignored
    idle(3);

    // 1-clock windows, 1,1,0,0,0,0,0,0
    send_byte(8'hC0, 1, 1'b0);
    chk("c0_msb_out", {24'd0, if0.data_out}, 32'hC0);
    chk("03_lsb_out", {24'd0, if1.data_out}, 32'h03);
    ack_pulse();

    // overrun: 0x11 unacked, then 0x22 dropped
    send_byte(8'h11, 2, 1'b0);
    idle(2);
    send_byte(8'h22, 1, 1'b0);
    chk("ovr_out_kept", {24'd0, if0.data_out}, 32'h11);
    chk("ovr_set",      {31'd0, if0.overrun}, 32'd1);
    idle(2);
    ack_pulse();
    chk("ovr_ack_valid", {31'd0, if0.data_valid}, 32'd0);
    chk("ovr_ack_clear", {31'd0, if0.overrun}, 32'd0);

    // ack coincident with the 8th capture
    send_byte(8'h3C, 2, 1'b0);
    send_byte(8'h5A, 4, 1'b1);
    chk("ackc_out",   {24'd0, if0.data_out}, 32'h5A);
    chk("ackc_valid", {31'd0, if0.data_valid}, 32'd1);
    chk("ackc_ovr",   {31'd0, if0.overrun}, 32'd0);
    ack_pulse();

    // timeout: 3 bits, then idle until the 16th idle clock
    win_bit(1'b1, 2, 1'b0);
    win_bit(1'b0, 1, 1'b0);
    win_bit(1'b1, 3, 1'b0);
    chk("tmo_bits_held", {29'd0, if0.bit_cnt}, 32'd3);
    idle(14);
    chk("tmo_not_yet", {31'd0, if0.frame_err}, 32'd0);
    idle(1);
    chk("tmo_pulse",   {31'd0, if0.frame_err}, 32'd1);
    chk("tmo_bit_cnt", {29'd0, if0.bit_cnt}, 32'd0);
    idle(1);
    chk("tmo_one_clk", {31'd0, if0.frame_err}, 32'd0);
    send_byte(8'h96, 2, 1'b0);
    chk("tmo_clean_byte", {24'd0, if0.data_out}, 32'h96);
    ack_pulse();
    idle(40);               // long idle with no partial byte

    // reset mid-byte with data_valid=1, window open across release
    send_byte(8'h77, 1, 1'b0);
    for (int i = 0; i < 5; i++) win_bit(1'($urandom), 2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out",     {24'd0, if0.data_out}, 32'h00);
    chk("arst_valid",   {31'd0, if0.data_valid}, 32'd0);
    chk("arst_bit_cnt", {29'd0, if0.bit_cnt}, 32'd0);
    sser = 1'b0; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1; sdrd = 1'b1;
    clk1();
    rst_n = 1'b1;
    clk1();
    sser = 1'b1; sdrd = 1'b0;
    clk1();
    rest();
    chk("rel_first_bit", {29'd0, if0.bit_cnt}, 32'd1);
    begin
      logic [7:0] rem;
      rem = 8'hB3;
      for (int i = 6; i >= 0; i--) win_bit(rem[i], 2, 1'b0);
    end
    chk("rst_byte_out",   {24'd0, if0.data_out}, 32'hB3);
    chk("rst_byte_valid", {31'd0, if0.data_valid}, 32'd1);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
